// File: rtl/my_pkg.sv
// Shared helpers for the status word packer.
//   popcount : number of set bits in the low `width` bits of a word
//   sat_inc  : increment of a `width`-bit value that sticks at all-ones
// Both functions take a maximum-width operand plus the live width so one
// definition serves every parameterisation of the packer.
package my_pkg;

  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MaxCntW  = 64;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} pack_state_e;

  function automatic int unsigned popcount(input logic [MaxWidth-1:0] word,
                                           input int unsigned         width);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < MaxWidth; i++) begin
      if (i >= width) return cnt;
      if (word[i]) cnt++;
    end
    return cnt;
  endfunction

  function automatic logic [MaxCntW-1:0] sat_inc(input logic [MaxCntW-1:0] value,
                                                 input int unsigned        width);
    logic [MaxCntW:0] all_ones;
    // One spare bit so a full-width counter still gets a correct mask.
    all_ones = ((MaxCntW + 1)'(1) << width) - (MaxCntW + 1)'(1);
    if ({1'b0, value} == all_ones) return value;
    return value + MaxCntW'(1);
  endfunction

endpackage

// File: rtl/status_word_packer.sv
// Packs a serial status bit stream into WIDTH-bit words, LSB first, and
// presents each word with its population count on a valid/ready port.
// Counts delivered words with an odd number of ones (saturating).
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   in_valid   : in_bit is valid
//   in_ready   : a bit is accepted this cycle (low only while a word is held)
//   in_bit     : serial status bit
//   flush      : close the current partial word, zero padded
//   out_valid  : out_data / out_ones valid
//   out_ready  : consumer takes the word
//   out_data   : packed word
//   out_ones   : number of ones in out_data
//   odd_cnt    : saturating count of delivered odd-parity words
module status_word_packer
  import my_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_bit,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH+1)-1:0] out_ones,
  output logic [CNT_W-1:0]           odd_cnt
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned OW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > MaxWidth) begin : g_bad_width
    $error("status_word_packer: WIDTH out of range");
  end
  if (CNT_W < 1 || CNT_W > MaxCntW) begin : g_bad_cnt_w
    $error("status_word_packer: CNT_W out of range");
  end

  pack_state_e      state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] shreg_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [OW-1:0]    out_ones_q;
  logic [CNT_W-1:0] odd_cnt_q;

  logic             accept;
  logic             close;
  logic [WIDTH-1:0] word_next;

  // in_ready depends on the state register only.
  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  // Partial word with this cycle's bit (if any) already placed at idx.
  always_comb begin
    word_next = shreg_q;
    if (accept) word_next[idx_q] = in_bit;
  end

  // A word closes on its last bit, or on flush when it holds at least one
  // bit (either already stored in FILL, or arriving this cycle).
  always_comb begin
    close = 1'b0;
    if (accept && idx_q == LastIdx) close = 1'b1;
    if (flush && (state_q == FILL || accept)) close = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      shreg_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ones_q  <= '0;
      odd_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, FILL: begin
          if (close) begin
            out_data_q  <= word_next;
            out_ones_q  <= OW'(popcount(MaxWidth'(word_next), WIDTH));
            out_valid_q <= 1'b1;
            shreg_q     <= '0;
            idx_q       <= '0;
            state_q     <= HOLD;
          end else if (accept) begin
            shreg_q <= word_next;
            idx_q   <= idx_q + IW'(1);
            state_q <= FILL;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
            if (out_ones_q[0]) begin
              odd_cnt_q <= CNT_W'(sat_inc(MaxCntW'(odd_cnt_q), CNT_W));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ones  = out_ones_q;
  assign odd_cnt   = odd_cnt_q;

endmodule

// File: doc/status_word_packer.md
# status_word_packer

Downstream consumer of the 1-bit status output `o` produced by the `top` test block in `my_pkg`-based simple tests. Collects the serial status bits into `WIDTH`-bit words and presents each word on a valid/ready output with its population count. Keeps a saturating count of delivered odd-parity words. Bit counting and saturation use `my_pkg` functions that end in an early `return`, so the synthesis flow's task/function-return handling is also exercised on sequential logic.

## Interface
- `WIDTH`, 8: word width in bits; must be ≥ 2.
- `CNT_W`, 16: width of the odd-parity word counter.

- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_bit` is valid this cycle.
- `in_ready` output 1: the block accepts a bit this cycle.
- `in_bit` input 1: serial status bit (driven from `top.o`).
- `flush` input 1: close the current partial word, padding it with zeros.
- `out_valid` output 1: `out_data` and `out_ones` are valid.
- `out_ready` input 1: the consumer accepts the word.
- `out_data` output `WIDTH`: packed word.
- `out_ones` output `$clog2(WIDTH+1)`: number of 1 bits in `out_data`.
- `odd_cnt` output `CNT_W`: count of delivered words with odd `out_ones`; saturates.

## Operation
- FSM states: `IDLE` (no bits held), `FILL` (1 to `WIDTH-1` bits held), `HOLD` (word presented).
- A bit is accepted when `in_valid && in_ready`.
- `in_ready` is 1 in `IDLE` and `FILL`, and 0 in `HOLD`.
- Packing is LSB-first: the k-th accepted bit of a word lands in `out_data[k]`. Bit index counter `idx` is `$clog2(WIDTH)` wide.
- `IDLE` → `FILL` on an accept. `FILL` → `HOLD` when the accepted bit is bit `WIDTH-1`.
- `flush` in `FILL`: go to `HOLD`; unfilled bits are 0.
  - If a bit is accepted in the same cycle, that bit is packed first and then the word closes.
- `flush` in `IDLE` with no accept: ignored.
- `flush` in `IDLE` with an accept: a 1-bit word goes to `HOLD`.
- `flush` in `HOLD`: ignored.
- On entering `HOLD`: `out_ones` = `my_pkg::popcount(word)`, registered. The function loops over bits and returns early at `WIDTH`.
- `HOLD` → `IDLE` on `out_valid && out_ready`. On that same edge, if `out_ones[0]` is 1, `odd_cnt` = `my_pkg::sat_inc(odd_cnt)`.
  - `sat_inc` returns its input unchanged, via early `return`, when the input is all-ones; otherwise it returns input + 1.
- `out_data`, `out_ones`, `out_valid` are held stable while `out_valid && !out_ready`.
- Reset in any state: return to `IDLE`, discard the partial word, clear `idx`. Any presented word is dropped without being counted.

## Timing
- Reset values:
  - `in_ready` = 1 (combinational from state).
  - `out_valid` = 0, `out_data` = 0, `out_ones` = 0, `odd_cnt` = 0.
- Latency: `out_valid` rises on the cycle after the accept of bit `WIDTH-1` or the flush.
- Throughput: one word per `WIDTH + 1` cycles under continuous `in_valid` and `out_ready`. The bubble is the `HOLD` cycle, where `in_ready` = 0.
- `out_valid`, `out_data`, `out_ones` are registered outputs. `in_ready` is combinational from the state register only; it has no path from `in_valid` or `out_ready`.
- `odd_cnt` updates on the handshake edge and is visible the next cycle.

## Structure
- Shared package `my_pkg`:
  - `function automatic popcount` (parameterised through a `WIDTH`-sized input) and `function automatic sat_inc`, both written with explicit early `return`.
  - `typedef enum logic [1:0] {IDLE, FILL, HOLD} pack_state_e`.
- No sub-module. The block is a single module of the FSM, shift register and counter, roughly 150 lines.
- Test wrapper instantiates `top` and drives `in_bit` from `top.o`.

## Test plan
- Reset, then 8 accepts of bits 1,0,1,1,0,0,0,1 with `out_ready`=1 → `out_data`=0x8D, `out_ones`=4, `odd_cnt` stays 0, `in_ready`=0 for exactly 1 cycle.
- 3 accepts of 1,1,1, then `flush` with no accept → `out_data`=0x07, `out_ones`=3, `odd_cnt`=1 after the handshake.
- Full word 0xFF with `out_ready`=0 for 5 cycles → `out_valid` and data stable; `in_valid`=1 is not accepted (`in_ready`=0); on release `odd_cnt` is unchanged (8 ones is even).
- `flush` in `IDLE` together with accept of bit 1 → a 1-bit word `out_data`=0x01, `out_ones`=1.
- `CNT_W`=2 with 5 odd-parity words delivered → `odd_cnt` reads 1,2,3,3,3 (saturates).
- Assert `rst` for one cycle after 5 accepts, and again while in `HOLD` → outputs at reset values the next cycle; the next 8 bits form a fresh word starting at bit 0.
